jtframe_dump_seq: RTL

//  Synthesizable sequencer that decides when waveform/probe capture is active. It counts video frames from vertical sync
//  and optionally waits for the end of a ROM download, then opens a capture window from a start frame to a stop frame.

---
 rtl/jtframe_dump_pkg.sv | 15 +
 rtl/jtframe_dump_seq_if.sv | 24 ++
 rtl/jtframe_dump_edge.sv | 31 +++
 rtl/jtframe_dump_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/jtframe_dump_pkg.sv
// Shared types and constants for the capture-window sequencer.
package jtframe_dump_pkg;

  localparam int unsigned STW      = 3;
  localparam int unsigned CNTW_DEF = 32;

  typedef enum logic [STW-1:0] {
    ST_HOLD  = 3'd0,
    ST_LOADW = 3'd1,
    ST_ARMED = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/jtframe_dump_seq_if.sv
// Bus bundle between the capture sequencer and its environment.
interface jtframe_dump_seq_if #(
  parameter int unsigned CNTW = jtframe_dump_pkg::CNTW_DEF
);
  logic                              vs;
  logic                              downloading;
  logic [CNTW-1:0]                   start_frame;
  logic [CNTW-1:0]                   stop_frame;
  logic [CNTW-1:0]                   frame_cnt;
  logic                              dump_on;
  logic                              dump_start;
  logic                              dump_stop;
  logic [jtframe_dump_pkg::STW-1:0]  st;

  modport master (
    output vs, downloading, start_frame, stop_frame,
    input  frame_cnt, dump_on, dump_start, dump_stop, st
  );

  modport slave (
    input  vs, downloading, start_frame, stop_frame,
    output frame_cnt, dump_on, dump_start, dump_stop, st
  );
endinterface

// File: rtl/jtframe_dump_edge.sv
// Two-flop synchroniser plus edge register; yields fall/rise pulses and the synced level.
module jtframe_dump_edge #(
  parameter logic RSTVAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_fe_c,
  output logic o_re_c,
  output logic o_lvl_c
);

  logic r_s1, r_s2, r_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= RSTVAL;
      r_s2 <= RSTVAL;
      r_l  <= RSTVAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_l  <= r_s2;
    end
  end

  assign o_fe_c  = r_l & ~r_s2;
  assign o_re_c  = ~r_l & r_s2;
  assign o_lvl_c = r_s2;

endmodule

// File: rtl/jtframe_dump_seq.sv
// Frame counter and capture-window FSM: opens dump_on between a start and a stop frame.
module jtframe_dump_seq
  import jtframe_dump_pkg::*;
#(
  parameter int unsigned CNTW      = CNTW_DEF,
  parameter int unsigned WAIT_LOAD = 0,
  parameter int unsigned HOLD_CYC  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_dump_seq_if.slave  io_bus
);

  localparam int unsigned HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  logic            w_fe_vs, w_re_vs, w_lvl_vs;
  logic            w_fe_dl, w_re_dl, w_lvl_dl;
  logic            w_unused;
  logic [CNTW-1:0] r_frame_cnt;
  logic [CNTW-1:0] w_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic            w_hold_done;
  state_t          r_state, w_state_nxt;
  logic            r_dump_on, r_dump_start, r_dump_stop;
  logic            w_dump_on_nxt, w_start_nxt, w_stop_nxt;

  jtframe_dump_edge #(.RSTVAL(1'b1)) u_vs (
    .clk     (clk),
    .rst     (rst),
    .i_d     (io_bus.vs),
    .o_fe_c  (w_fe_vs),
    .o_re_c  (w_re_vs),
    .o_lvl_c (w_lvl_vs)
  );

  jtframe_dump_edge #(.RSTVAL(1'b0)) u_dl (
    .clk     (clk),
    .rst     (rst),
    .i_d     (io_bus.downloading),
    .o_fe_c  (w_fe_dl),
    .o_re_c  (w_re_dl),
    .o_lvl_c (w_lvl_dl)
  );

  assign w_unused    = &{1'b0, w_re_vs, w_lvl_vs, w_lvl_dl};
  assign w_nxt       = r_frame_cnt + CNTW'(1);
  assign w_hold_done = (r_hold_cnt == HW'(HOLD_CYC));

  // Frame counter wraps naturally at CNTW bits
  always_ff @(posedge clk) begin
    if (rst)          r_frame_cnt <= '0;
    else if (w_fe_vs) r_frame_cnt <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    r_hold_cnt <= '0;
    else if (r_state == ST_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HOLD;
    else     r_state <= w_state_nxt;
  end

  // A new download start overrides any frame event and re-arms the window
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_HOLD:  if (w_hold_done) w_state_nxt = (WAIT_LOAD != 0) ? ST_LOADW : ST_ARMED;
      ST_LOADW: if (w_fe_dl) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (io_bus.start_frame == '0)                        w_state_nxt = ST_DUMP;
        else if (w_fe_vs && (w_nxt == io_bus.start_frame))   w_state_nxt = ST_DUMP;
      end
      ST_DUMP:  if (w_fe_vs && (io_bus.stop_frame != '0) && (w_nxt == io_bus.stop_frame))
                  w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_HOLD;
    endcase
    if ((WAIT_LOAD != 0) && w_re_dl &&
        (r_state == ST_ARMED || r_state == ST_DUMP || r_state == ST_DONE))
      w_state_nxt = ST_LOADW;
  end

  always_comb begin
    w_dump_on_nxt = 1'b0;
    w_start_nxt   = 1'b0;
    w_stop_nxt    = 1'b0;
    w_dump_on_nxt = (w_state_nxt == ST_DUMP);
    w_start_nxt   = w_dump_on_nxt & ~r_dump_on;
    w_stop_nxt    = ~w_dump_on_nxt & r_dump_on;
  end

  // Pulses line up with the dump_on transition; reset clears without a stop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_on    <= 1'b0;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
    end else begin
      r_dump_on    <= w_dump_on_nxt;
      r_dump_start <= w_start_nxt;
      r_dump_stop  <= w_stop_nxt;
    end
  end

  assign io_bus.frame_cnt  = r_frame_cnt;
  assign io_bus.dump_on    = r_dump_on;
  assign io_bus.dump_start = r_dump_start;
  assign io_bus.dump_stop  = r_dump_stop;
  assign io_bus.st         = r_state;

endmodule
